secuenciador_ud: RTL

- Moore FSM control unit that executes one register-transfer operation `Z <= X op Y` on the `UnidadDatos` datapath per start request.
- Datapath resources it sequences: registers A, B, C and AC on the shared bus, holding register T, and the add/sub ALU.
- Sits between the top-level `SD` start input `xs` and the datapath control strobes `Ra…Wt, S, R`.
- Replaces the empty control-unit slot in `SD`.

---
 rtl/secuenciador_ud_if.sv | 33 +++
 rtl/secuenciador_ud.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/secuenciador_ud_if.sv
// Request/strobe bundle between the SD start logic, secuenciador_ud and UnidadDatos.
// master drives the request fields; slave is the control unit that drives the strobes.
interface secuenciador_ud_if;
  logic       xs;
  logic       op;
  logic [1:0] src1;
  logic [1:0] src2;
  logic [1:0] dst;
  logic       Ra;
  logic       Rb;
  logic       Rc;
  logic       Rac;
  logic       Wa;
  logic       Wb;
  logic       Wc;
  logic       Wac;
  logic       Wt;
  logic       S;
  logic       R;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output xs, op, src1, src2, dst,
    input  Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R, busy, done, err
  );

  modport slave (
    input  xs, op, src1, src2, dst,
    output Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R, busy, done, err
  );
endinterface

// File: rtl/secuenciador_ud.sv
// Moore control unit sequencing one Z <= X op Y transfer on UnidadDatos per start request.
// Define UC_GUARD_EN to insert an idle bus-turnaround GAP cycle after LOAD_T and after EXEC.
module secuenciador_ud (
  input  logic             clk,
  input  logic             reset,
  secuenciador_ud_if.slave bus_if
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_T = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4,
    ST_GAP1   = 3'd5,
    ST_GAP2   = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic       op_q, op_d;
  logic [1:0] src1_q, src1_d;
  logic [1:0] src2_q, src2_d;
  logic [1:0] dst_q, dst_d;
  logic       ill_q, ill_d;

  logic [3:0] rd_s;
  logic [3:0] wr_s;
  logic       wt_s;
  logic       s_s;
  logic       r_s;
  logic       busy_s;
  logic       done_s;
  logic       err_s;

  // Operand select to one-hot {Ra, Rb, Rc, Rac}.
  function automatic logic [3:0] rd_dec(input logic [1:0] sel);
    case (sel)
      2'b00:   rd_dec = 4'b1000;
      2'b01:   rd_dec = 4'b0100;
      2'b10:   rd_dec = 4'b0010;
      2'b11:   rd_dec = 4'b0001;
      default: rd_dec = 4'b0000;
    endcase
  endfunction

  // Destination select to one-hot {Wa, Wb, Wc, Wac}; AC is never a destination.
  function automatic logic [3:0] wr_dec(input logic [1:0] sel);
    case (sel)
      2'b00:   wr_dec = 4'b1000;
      2'b01:   wr_dec = 4'b0100;
      2'b10:   wr_dec = 4'b0010;
      default: wr_dec = 4'b0000;
    endcase
  endfunction

  // State and latched request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= 1'b0;
      src1_q  <= 2'b00;
      src2_q  <= 2'b00;
      dst_q   <= 2'b00;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dst_q   <= dst_d;
      ill_q   <= ill_d;
    end
  end

  // Next state; an illegal destination skips straight to DONE to report err.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.xs) begin
          if (bus_if.dst == 2'b11) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD_T;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef UC_GUARD_EN
      ST_LOAD_T: state_d = ST_GAP1;
      ST_EXEC:   state_d = ST_GAP2;
`else
      ST_LOAD_T: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WRITE;
`endif
      ST_GAP1:   state_d = ST_EXEC;
      ST_GAP2:   state_d = ST_WRITE;
      ST_WRITE:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured only when a start is accepted, then held.
  always_comb begin
    op_d   = op_q;
    src1_d = src1_q;
    src2_d = src2_q;
    dst_d  = dst_q;
    ill_d  = ill_q;
    if ((state_q == ST_IDLE) && bus_if.xs) begin
      op_d   = bus_if.op;
      src1_d = bus_if.src1;
      src2_d = bus_if.src2;
      dst_d  = bus_if.dst;
      ill_d  = (bus_if.dst == 2'b11);
    end else begin
      ill_d  = ill_q;
    end
  end

  // Moore strobe decode from state and latched fields.
  always_comb begin
    rd_s   = 4'b0000;
    wr_s   = 4'b0000;
    wt_s   = 1'b0;
    s_s    = 1'b0;
    r_s    = 1'b0;
    busy_s = 1'b0;
    done_s = 1'b0;
    err_s  = 1'b0;
    case (state_q)
      ST_LOAD_T: begin
        rd_s   = rd_dec(src1_q);
        wt_s   = 1'b1;
        busy_s = 1'b1;
      end
      ST_EXEC: begin
        // With src2 = AC the old AC drives the bus while Wac captures the ALU result.
        rd_s   = rd_dec(src2_q);
        wr_s   = 4'b0001;
        s_s    = ~op_q;
        r_s    = op_q;
        busy_s = 1'b1;
      end
      ST_WRITE: begin
        rd_s   = 4'b0001;
        wr_s   = wr_dec(dst_q);
        busy_s = 1'b1;
      end
      ST_GAP1, ST_GAP2: busy_s = 1'b1;
      ST_DONE: begin
        done_s = ~ill_q;
        err_s  = ill_q;
      end
      default: busy_s = 1'b0;
    endcase
  end

  assign bus_if.Ra   = rd_s[3];
  assign bus_if.Rb   = rd_s[2];
  assign bus_if.Rc   = rd_s[1];
  assign bus_if.Rac  = rd_s[0];
  assign bus_if.Wa   = wr_s[3];
  assign bus_if.Wb   = wr_s[2];
  assign bus_if.Wc   = wr_s[1];
  assign bus_if.Wac  = wr_s[0];
  assign bus_if.Wt   = wt_s;
  assign bus_if.S    = s_s;
  assign bus_if.R    = r_s;
  assign bus_if.busy = busy_s;
  assign bus_if.done = done_s;
  assign bus_if.err  = err_s;

endmodule
